// File: rtl/mem_arb.sv
// mem_arb: two-port arbiter in front of a single shared memory port.
// Each granted access runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE.
// The winner's request is latched at grant, so port inputs may change
// mid-transaction without effect.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin tie-break using a
// one-bit last-grant pointer. When it is undefined, port 0 always wins a tie.
module mem_arb #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    // Count value in the final ACCESS cycle, where read data is captured.
    localparam logic [3:0] LastCnt = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        pick1;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_q, last_d; // 1 = port 1 was granted most recently

    // Arbitration: a lone requester wins; on a tie the port not granted last wins.
    always_comb begin
        pick1 = req1 && (!req0 || !last_q);
    end
`else
    // Arbitration: a lone requester wins; on a tie port 0 wins.
    always_comb begin
        pick1 = req1 && !req0;
    end
`endif

    // Next-state logic: grant and latch in IDLE, count in ACCESS, release after DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d   = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                gnt_d = 2'b00;
                if (req0 || req1) begin
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    we_d    = pick1 ? we1 : we0;
                    addr_d  = pick1 ? addr1 : addr0;
                    wdata_d = pick1 ? wdata1 : wdata0;
                    cnt_d   = 4'd0;
                    state_d = StAccess;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = pick1;
`endif
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LastCnt) begin
                    if (!we_q) begin
                        if (gnt_q[1]) rdata1_d = mem_rdata;
                        else          rdata0_d = mem_rdata;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            gnt_q    <= 2'b00;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    // Outputs decode from registered state only; the strobe fires once per write.
    always_comb begin
        gnt       = gnt_q;
        busy      = (state_q != StIdle);
        ack0      = (state_q == StDone) && gnt_q[0];
        ack1      = (state_q == StDone) && gnt_q[1];
        mem_we    = (state_q == StAccess) && (cnt_q == 4'd0) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rdata0    = rdata0_q;
        rdata1    = rdata1_q;
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: three mem_arb instances (MEM_LAT = 1, 2, 3) driven with the same
// port stimulus; each has its own memory read data and is checked against
// cycle-indexed expectations derived from its latency.
module tb_mem_arb;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic [31:0] mrd_a       [1:3];
    logic        ack0_a      [1:3];
    logic        ack1_a      [1:3];
    logic [31:0] rdata0_a    [1:3];
    logic [31:0] rdata1_a    [1:3];
    logic [1:0]  gnt_a       [1:3];
    logic        busy_a      [1:3];
    logic [31:0] mem_addr_a  [1:3];
    logic [31:0] mem_wdata_a [1:3];
    logic        mem_we_a    [1:3];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [1:0] eg;
    logic [1:0] own;

    mem_arb #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0_a[1]), .ack1(ack1_a[1]), .rdata0(rdata0_a[1]), .rdata1(rdata1_a[1]),
        .gnt(gnt_a[1]), .busy(busy_a[1]), .mem_addr(mem_addr_a[1]),
        .mem_wdata(mem_wdata_a[1]), .mem_we(mem_we_a[1]), .mem_rdata(mrd_a[1])
    );

    mem_arb #(.MEM_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0_a[2]), .ack1(ack1_a[2]), .rdata0(rdata0_a[2]), .rdata1(rdata1_a[2]),
        .gnt(gnt_a[2]), .busy(busy_a[2]), .mem_addr(mem_addr_a[2]),
        .mem_wdata(mem_wdata_a[2]), .mem_we(mem_we_a[2]), .mem_rdata(mrd_a[2])
    );

    mem_arb #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0_a[3]), .ack1(ack1_a[3]), .rdata0(rdata0_a[3]), .rdata1(rdata1_a[3]),
        .gnt(gnt_a[3]), .busy(busy_a[3]), .mem_addr(mem_addr_a[3]),
        .mem_wdata(mem_wdata_a[3]), .mem_we(mem_we_a[3]), .mem_rdata(mrd_a[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s lat=%0d got=%h want=%h", tag, k, obs, exp);
        end
    endtask

    // Control outputs of instance k; busy must follow gnt being non-zero.
    task automatic chk_ctl(input string tag, input int k, input logic [1:0] egnt,
                           input logic ea0, input logic ea1, input logic ewe);
        chk({tag, ".gnt"},    k, 32'(gnt_a[k]),    32'(egnt));
        chk({tag, ".ack0"},   k, 32'(ack0_a[k]),   32'(ea0));
        chk({tag, ".ack1"},   k, 32'(ack1_a[k]),   32'(ea1));
        chk({tag, ".busy"},   k, 32'(busy_a[k]),   32'(egnt != 2'b00));
        chk({tag, ".mem_we"}, k, 32'(mem_we_a[k]), 32'(ewe));
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
        for (int k = 1; k <= 3; k++) mrd_a[k] = 32'd0;
        tick();
        tick();

        // Reset state
        for (int k = 1; k <= 3; k++) begin
            chk_ctl("rst", k, 2'b00, 1'b0, 1'b0, 1'b0);
            chk("rst.rdata0", k, rdata0_a[k], 32'd0);
            chk("rst.rdata1", k, rdata1_a[k], 32'd0);
            chk("rst.maddr", k, mem_addr_a[k], 32'd0);
            chk("rst.mwdata", k, mem_wdata_a[k], 32'd0);
        end
        rst = 1'b0;

        // Port 0 read of 0x10; req drops and addr0 changes after cycle 0.
        for (int c = 0; c <= 5; c++) begin
            if (c == 0) begin req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; end
            if (c == 1) begin req0 = 1'b0; addr0 = 32'h99; end
            for (int k = 1; k <= 3; k++) begin
                mrd_a[k] = (c == k) ? 32'hDEADBEEF : 32'h0BAD0BAD;
                eg = (c >= 1 && c <= k + 1) ? 2'b01 : 2'b00;
                chk_ctl("rd", k, eg, c == k + 1, 1'b0, 1'b0);
                if (c >= 1 && c <= k) chk("rd.maddr", k, mem_addr_a[k], 32'h10);
                if (c >= k + 2) begin
                    chk("rd.rdata0", k, rdata0_a[k], 32'hDEADBEEF);
                    chk("rd.rdata1", k, rdata1_a[k], 32'd0);
                end
            end
            tick();
        end

        // Port 1 write: one strobe in cycle 1, no rdata change.
        for (int c = 0; c <= 5; c++) begin
            if (c == 0) begin
                req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678;
            end
            if (c == 1) req1 = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                mrd_a[k] = 32'hFFFFFFFF;
                eg = (c >= 1 && c <= k + 1) ? 2'b10 : 2'b00;
                chk_ctl("wr", k, eg, 1'b0, c == k + 1, c == 1);
                if (c == 1) begin
                    chk("wr.maddr", k, mem_addr_a[k], 32'h20);
                    chk("wr.mwdata", k, mem_wdata_a[k], 32'h12345678);
                end
                if (c == 5) begin
                    chk("wr.rdata0", k, rdata0_a[k], 32'hDEADBEEF);
                    chk("wr.rdata1", k, rdata1_a[k], 32'd0);
                end
            end
            tick();
        end

        // Both ports requesting continuously; last grant so far was port 1.
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            for (int k = 1; k <= 3; k++) begin
                mrd_a[k] = 32'h0000C0DE;
`ifdef ARB_ROUND_ROBIN_EN
                own = ((c / (k + 2)) % 2 == 1) ? 2'b10 : 2'b01;
`else
                own = 2'b01;
`endif
                eg = ((c % (k + 2)) == 0) ? 2'b00 : own;
                chk_ctl("tie", k, eg, (c % (k + 2)) == k + 1 && own == 2'b01,
                        (c % (k + 2)) == k + 1 && own == 2'b10, 1'b0);
            end
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) tick();

        // Reset during the second ACCESS cycle of the MEM_LAT=3 instance.
        for (int c = 0; c <= 6; c++) begin
            if (c == 0) begin req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40; end
            if (c == 1) req0 = 1'b0;
            if (c == 2) rst = 1'b1;
            if (c == 3) rst = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                mrd_a[k] = 32'h5555AAAA;
                if (c <= 2) begin
                    eg = (c >= 1) ? 2'b01 : 2'b00;
                    chk_ctl("rrst", k, eg, c == 2 && k == 1, 1'b0, 1'b0);
                end else begin
                    chk_ctl("rrst", k, 2'b00, 1'b0, 1'b0, 1'b0);
                end
                if (c == 3) begin
                    chk("rrst.rdata0", k, rdata0_a[k], 32'd0);
                    chk("rrst.rdata1", k, rdata1_a[k], 32'd0);
                    chk("rrst.maddr", k, mem_addr_a[k], 32'd0);
                    chk("rrst.mwdata", k, mem_wdata_a[k], 32'd0);
                end
            end
            tick();
        end

        // First tie after reset goes to port 0; port 1 follows once req0 drops.
        for (int c = 0; c <= 11; c++) begin
            if (c == 0) begin req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; end
            if (c == 1) req0 = 1'b0;
            if (c == 6) req1 = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                mrd_a[k] = 32'h11112222;
                if (c >= 1 && c <= k + 1)              eg = 2'b01;
                else if (c >= k + 3 && c <= 2 * k + 3) eg = 2'b10;
                else                                   eg = 2'b00;
                chk_ctl("seq", k, eg, c == k + 1, c == 2 * k + 3, 1'b0);
                if (c == 11) begin
                    chk("seq.rdata0", k, rdata0_a[k], 32'h11112222);
                    chk("seq.rdata1", k, rdata1_a[k], 32'h11112222);
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter MEM_LAT, default 1, meaning memory read latency in cycles; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1 each  access request from port 0 (CPU) and port 1 (loader/DMA).
REQ-005 we0 / we1  input  1 each  1 = write, 0 = read, per port.
REQ-006 addr0 / addr1  input  32 each  byte address, per port.
REQ-007 wdata0 / wdata1  input  32 each  write data, per port.
REQ-008 ack0 / ack1  output  1 each  one-cycle completion pulse, per port.
REQ-009 rdata0 / rdata1  output  32 each  registered read data, per port.
REQ-010 gnt  output  2  one-hot current owner; bit0 = port 0, bit1 = port 1; 00 when idle.
REQ-011 busy  output  1  high in ACCESS and DONE states.
REQ-012 mem_addr / mem_wdata  output  32 each  shared memory address and write data.
REQ-013 mem_we  output  1  shared memory write strobe.
REQ-014 mem_rdata  input  32  shared memory read data, valid MEM_LAT cycles after address issue.

Function
REQ-015 FSM states are IDLE, ACCESS and DONE.
REQ-016 IDLE with any req sampled high: latch the winner's we/addr/wdata, set gnt, clear cnt, go to ACCESS.
REQ-017 IDLE with no req: stay in IDLE; gnt = 00; mem_we = 0.
REQ-018 ACCESS: mem_addr/mem_wdata come from the latched values; later changes on port inputs have no effect.
REQ-019 mem_we is high only in the first ACCESS cycle of a write; a write produces exactly one strobe.
REQ-020 ACCESS: cnt increments each cycle; when cnt == MEM_LAT-1, capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
REQ-021 DONE: the owner's ack is high for exactly one cycle; next state is IDLE; gnt is held through DONE.
REQ-022 Latency: req high in IDLE cycle 0 gives ack in cycle MEM_LAT+1; each transaction occupies MEM_LAT+2 cycles.
REQ-023 The non-owner's rdata register is unchanged; a write leaves both rdata registers unchanged.
REQ-024 Deasserting req mid-transaction does not abort it; the transaction completes and ack still pulses.
REQ-025 A requester holds req and its inputs stable until ack; a req still high in the IDLE cycle after DONE starts a new transaction.
REQ-026 When only one req is high, that port wins regardless of priority state.
REQ-027 Tie-break on simultaneous req0 and req1 follows REQ-031/REQ-032.
REQ-028 ack0 and ack1 are never high together; gnt is never 11.

Reset
REQ-029 rst high at a clock edge (including mid-ACCESS or in DONE) forces: IDLE, cnt = 0, gnt = 00, busy = 0, ack0 = ack1 = 0, mem_we = 0, rdata0 = rdata1 = 0, mem_addr = mem_wdata = 0, last-grant pointer = port 1.
REQ-030 An access interrupted by reset produces no ack and no further mem_we.

Configuration
REQ-031 With ARB_ROUND_ROBIN_EN defined: a one-bit last-grant pointer updates at each grant; on a tie the port not granted last wins; after reset, port 0 wins the first tie.
REQ-032 Without ARB_ROUND_ROBIN_EN: fixed priority; port 0 always wins a tie; the pointer is not implemented.

Verification
REQ-033 MEM_LAT=1, req0 read addr=0x10, memory returns 0xDEADBEEF -> gnt=01 cycles 1-2, ack0 in cycle 2, rdata0=0xDEADBEEF, rdata1 unchanged.
REQ-034 MEM_LAT=3, req1 write addr=0x20, wdata=0x12345678 -> mem_we high in cycle 1 only with mem_addr=0x20 and mem_wdata=0x12345678; ack1 in cycle 4.
REQ-035 Round robin, req0 and req1 held high continuously -> grants alternate 0,1,0,1; ack0 and ack1 never coincide.
REQ-036 Fixed priority, req0 and req1 held high -> only port 0 is acked; port 1 is served in the first IDLE cycle after req0 drops.
REQ-037 rst asserted in the second ACCESS cycle with MEM_LAT=3 -> next cycle is IDLE, gnt=00, no ack, rdata0=rdata1=0.
REQ-038 MEM_LAT=2, req0 drops after cycle 0 and addr0 changes -> ack0 still in cycle 3, mem_addr keeps the originally latched address.
